macguffin_round_ctrl: RTL
=========================

Name: macguffin_round_ctrl

Overview:
- Iterative round sequencer for the MacGuffin 64-bit block cipher: one round per clock, 32 rounds by default.
- Owns the 64-bit state register (four 16-bit words R0..R3, R0 = bits 63:48).
- Issues the round-key index, XORs the round key into the 48-bit F-function input, and folds the 16-bit F result back into the state.
- The F path (P-box + 8 S-boxes) is external and purely combinational; f_out must be valid in the same cycle as f_in.

Parameters:
- ROUNDS, 32: number of rounds per block; must be >= 2.
- IDX_W, $clog2(ROUNDS): width of the round-key index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  controller can accept a block.
- in_block  in  64  plaintext (encrypt) or ciphertext (decrypt).
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with in_block.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_block  out  64  result block.
- rk_idx  out  IDX_W  round-key index presented to the key store.
- rk  in  48  round key for rk_idx, combinational from the key store.
- f_in  out  48  key-mixed input to the F path.
- f_out  in  16  F path result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, active-low. Reset is the only initialisation of the state register.
  - Values while rst_n = 0: state IDLE, round counter 0, state register 0, mode 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, busy = 0, out_block = 0, rk_idx = 0, f_in = 0.
  - Reset mid-RUN or mid-DONE abandons the block with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, load state <= in_block, mode <= in_decrypt, cnt <= 0, go to RUN.
  - RUN: in_ready = 0. Each cycle performs one round, then cnt <= cnt + 1. The round with cnt == ROUNDS-1 goes to DONE.
  - DONE: out_valid = 1, out_block = state. Hold until out_ready. On out_valid & out_ready go to IDLE.
  - in_ready is never asserted in DONE; there is no same-cycle handoff.
- Round key index during RUN:
  - Encrypt: rk_idx = cnt.
  - Decrypt: rk_idx = ROUNDS-1-cnt.
  - Outside RUN: rk_idx = 0.
- Encrypt round:
  - f_in = {R1,R2,R3} ^ rk.
  - Next state = {R1, R2, R3, R0 ^ f_out} (one-word left rotate).
- Decrypt round:
  - f_in = {R0,R1,R2} ^ rk.
  - Next state = {R3 ^ f_out, R0, R1, R2}.
- f_in is 0 outside RUN.
- Latency: accept at cycle t; rounds run in cycles t+1 .. t+ROUNDS; out_valid first high at t+ROUNDS+1.
- Throughput: one block per ROUNDS+2 cycles with out_ready held high.
- Boundary conditions:
  - in_valid is ignored outside IDLE.
  - in_block and in_decrypt may change freely after acceptance.
  - out_block is stable while out_valid & !out_ready.
  - The round counter is exactly IDX_W bits. Terminal compare is against ROUNDS-1, so non-power-of-two ROUNDS never wraps into an invalid index.

Optional Feature:
- Macro: MACGUFFIN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in RUN or DONE forces IDLE on the next edge.
  - out_valid is deasserted and the state register is cleared to 0; no output handshake occurs.
  - abort in IDLE is ignored.
  - abort and in_valid together in IDLE: the block is accepted.
- Undefined: no abort port; behaviour is exactly as above.

Test Plan:
- Stub F path: f_out = f_in[47:32] ^ f_in[31:16] ^ f_in[15:0].
- Stub key store: rk = {3{16'(rk_idx) * 16'h0101}}.
- Scenarios:
  - Reset hold 3 cycles -> in_ready = 1, out_valid = 0, busy = 0, rk_idx = 0, f_in = 0.
  - f_out forced 0, encrypt 64'h0001_0002_0003_0004 accepted at cycle t -> out_valid at t+33 with out_block = 64'h0001_0002_0003_0004 (32 word rotations); rk_idx steps 0..31.
  - Stub F, encrypt 64'h0123_4567_89AB_CDEF -> C matches the bench reference model. Decrypt C -> 64'h0123_4567_89AB_CDEF, with rk_idx stepping 31..0.
  - out_ready held 0 for 10 cycles after out_valid -> out_block stable, in_ready = 0, in_valid pulses ignored. out_ready = 1 -> IDLE next cycle.
  - rst_n low for 1 cycle at round 15 -> next cycle IDLE, no out_valid. A new block then completes correctly.
  - MACGUFFIN_ABORT_EN: abort at round 10 -> IDLE next cycle, state = 0, no out_valid. Next block completes with correct result.

Source files
------------

// File: rtl/macguffin_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : macguffin_round_ctrl_if
// Description : Block in/out handshake bundle for the MacGuffin round sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface macguffin_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

    modport master (
        output in_valid, in_block, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_decrypt, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface
`default_nettype wire

// File: rtl/macguffin_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : macguffin_round_ctrl
// Description : Iterative MacGuffin round sequencer, one round per clock.
//               Optional MACGUFFIN_ABORT_EN adds an abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module macguffin_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    macguffin_round_ctrl_if.slave  bus,
    output logic [IDX_W-1:0]       rk_idx,
    input  wire logic [47:0]       rk,
    output logic [47:0]            f_in,
    input  wire logic [15:0]       f_out,
    output logic                   busy
`ifdef MACGUFFIN_ABORT_EN
    ,
    input  wire logic              abort
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(ROUNDS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [63:0]      r_blk;
    logic             r_mode;
    logic [63:0]      w_blk_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_abort;

    logic [15:0] w_r0, w_r1, w_r2, w_r3;
    assign w_r0 = r_blk[63:48];
    assign w_r1 = r_blk[47:32];
    assign w_r2 = r_blk[31:16];
    assign w_r3 = r_blk[15:0];

`ifdef MACGUFFIN_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_block = '0;
        busy          = 1'b0;
        rk_idx        = '0;
        f_in          = '0;
        w_blk_nxt     = r_blk;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                // Decrypt walks the key schedule backwards and rotates right.
                if (r_mode) begin
                    rk_idx    = C_LAST - r_cnt;
                    f_in      = {w_r0, w_r1, w_r2} ^ rk;
                    w_blk_nxt = {w_r3 ^ f_out, w_r0, w_r1, w_r2};
                end else begin
                    rk_idx    = r_cnt;
                    f_in      = {w_r1, w_r2, w_r3} ^ rk;
                    w_blk_nxt = {w_r1, w_r2, w_r3, w_r0 ^ f_out};
                end
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_block = r_blk;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_step      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_blk  <= '0;
            r_mode <= 1'b0;
        end else if (w_abort) begin
            r_cnt <= '0;
            r_blk <= '0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_blk  <= bus.in_block;
            r_mode <= bus.in_decrypt;
        end else if (w_step) begin
            r_cnt <= r_cnt + IDX_W'(1);
            r_blk <= w_blk_nxt;
        end
    end

endmodule
`default_nettype wire
